// File: rtl/hdlc_rx_deframer.sv
// -----------------------------------------------------------------------------
// hdlc_rx_deframer
//   Serial front-end of the HDLC receive path. Samples the Rx line, detects
//   flags (01111110) and aborts (0 followed by seven 1s), removes stuffed
//   zeros inside a frame and assembles data bytes LSB-first.
//
// Ports
//   Clk             system clock, all logic on posedge
//   Rst             asynchronous active-low reset
//   Rx_Enable       1 = receiver active, 0 = held idle with frame state cleared
//   Rx              serial line, one bit per clock
//   Rx_Data         assembled byte, valid while Rx_NewByte = 1
//   Rx_NewByte      one-cycle strobe per assembled data byte
//   Rx_WrBuff       Rx_NewByte gated by !Rx_Overflow
//   Rx_FlagDetect   one-cycle strobe, flag seen
//   Rx_AbortDetect  one-cycle strobe, abort pattern seen
//   Rx_ValidFrame   high between opening and closing flag
//   Rx_EoF          one-cycle strobe, the cycle after Rx_ValidFrame falls
//   Rx_AbortSignal  one-cycle strobe, abort occurred inside a frame
//   Rx_Overflow     MAX_BYTES bytes received in the current frame
//   Rx_FrameError   one-cycle strobe with Rx_EoF, closing flag off byte boundary
// -----------------------------------------------------------------------------
module hdlc_rx_deframer #(
    parameter int MAX_BYTES = 128,
    parameter int BYTE_W    = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Rx_Enable,
    input  logic              Rx,
    output logic [BYTE_W-1:0] Rx_Data,
    output logic              Rx_NewByte,
    output logic              Rx_WrBuff,
    output logic              Rx_FlagDetect,
    output logic              Rx_AbortDetect,
    output logic              Rx_ValidFrame,
    output logic              Rx_EoF,
    output logic              Rx_AbortSignal,
    output logic              Rx_Overflow,
    output logic              Rx_FrameError
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);
    localparam int BIT_W = $clog2(BYTE_W);
    // Pattern register shifts in at bit 7, so bit 0 holds the oldest bit.
    localparam logic [7:0] FLAG_PAT  = 8'b0111_1110;
    localparam logic [7:0] ABORT_PAT = 8'b1111_1110;

    typedef enum logic {S_IDLE, S_FRAME} state_t;

    state_t            state_q, state_d;
    logic              rx_q, rx_d;
    logic [7:0]        pat_q, pat_d;
    logic              flag_q, flag_d;
    logic              abort_q, abort_d;
    logic [2:0]        skip_q, skip_d;
    logic [2:0]        ones_q, ones_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              any_bits_q, any_bits_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              ovf_q, ovf_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              newbyte_q, newbyte_d;
    logic              wrbuff_q, wrbuff_d;
    logic              abort_sig_q, abort_sig_d;
    logic              prev_frame_q, prev_frame_d;
    logic              eof_q, eof_d;
    logic              fe_pend_q, fe_pend_d;
    logic              fe_q, fe_d;

    logic flag_hit, abort_hit, out_bit, in_frame, stuffed, keep;

    assign flag_hit  = (pat_q == FLAG_PAT);
    assign abort_hit = (pat_q == ABORT_PAT);
    assign out_bit   = pat_q[0];
    assign in_frame  = (state_q == S_FRAME);
    assign stuffed   = (ones_q == 3'd5) && !out_bit;
    // The bit leaving the pattern register is data unless it belongs to a
    // flag/abort: the oldest one is dropped on the match itself and the
    // remaining seven by the skip counter.
    assign keep      = in_frame && !flag_hit && !abort_hit && (skip_q == 3'd0) && !stuffed;

    always_comb begin
        state_d      = state_q;
        rx_d         = Rx;
        pat_d        = {rx_q, pat_q[7:1]};
        flag_d       = flag_hit;
        abort_d      = abort_hit;
        skip_d       = skip_q;
        ones_d       = 3'd0;
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        any_bits_d   = any_bits_q;
        byte_cnt_d   = byte_cnt_q;
        ovf_d        = (byte_cnt_q == CNT_W'(MAX_BYTES));
        data_d       = data_q;
        newbyte_d    = 1'b0;
        wrbuff_d     = 1'b0;
        abort_sig_d  = 1'b0;
        prev_frame_d = in_frame;
        eof_d        = prev_frame_q && !in_frame;
        fe_pend_d    = 1'b0;
        fe_d         = fe_pend_q;

        if (flag_hit || abort_hit) begin
            skip_d = 3'd7;
        end else if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
        end

        // Consecutive data ones, used to spot the stuffed zero.
        if (in_frame && !flag_hit && !abort_hit && (skip_q == 3'd0) && out_bit) begin
            ones_d = (ones_q == 3'd7) ? ones_q : ones_q + 3'd1;
        end

        if (keep) begin
            shift_d    = {out_bit, shift_q[BYTE_W-1:1]};
            any_bits_d = 1'b1;
            if (bitcnt_q == BIT_W'(BYTE_W - 1)) begin
                bitcnt_d  = '0;
                data_d    = {out_bit, shift_q[BYTE_W-1:1]};
                newbyte_d = 1'b1;
                if (byte_cnt_q < CNT_W'(MAX_BYTES)) begin
                    wrbuff_d   = 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end else begin
                bitcnt_d = bitcnt_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (flag_q) begin
                    state_d    = S_FRAME;
                    byte_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            S_FRAME: begin
                if (abort_q) begin
                    state_d     = S_IDLE;
                    abort_sig_d = 1'b1;
                end else if (flag_q && any_bits_q) begin
                    // A flag with no bits since the last one is a shared or
                    // back-to-back flag and keeps the frame open.
                    state_d   = S_IDLE;
                    fe_pend_d = (bitcnt_q != '0);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Partial-byte state only lives inside a frame.
        if (state_q == S_IDLE) begin
            bitcnt_d   = '0;
            any_bits_d = 1'b0;
        end

        if (!Rx_Enable) begin
            state_d      = S_IDLE;
            rx_d         = 1'b1;
            pat_d        = '1;
            flag_d       = 1'b0;
            abort_d      = 1'b0;
            skip_d       = '0;
            ones_d       = '0;
            shift_d      = '0;
            bitcnt_d     = '0;
            any_bits_d   = 1'b0;
            byte_cnt_d   = '0;
            ovf_d        = 1'b0;
            data_d       = '0;
            newbyte_d    = 1'b0;
            wrbuff_d     = 1'b0;
            abort_sig_d  = 1'b0;
            prev_frame_d = 1'b0;
            eof_d        = 1'b0;
            fe_pend_d    = 1'b0;
            fe_d         = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= S_IDLE;
            rx_q         <= 1'b1;
            pat_q        <= '1;
            flag_q       <= 1'b0;
            abort_q      <= 1'b0;
            skip_q       <= '0;
            ones_q       <= '0;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            any_bits_q   <= 1'b0;
            byte_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            data_q       <= '0;
            newbyte_q    <= 1'b0;
            wrbuff_q     <= 1'b0;
            abort_sig_q  <= 1'b0;
            prev_frame_q <= 1'b0;
            eof_q        <= 1'b0;
            fe_pend_q    <= 1'b0;
            fe_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_q         <= rx_d;
            pat_q        <= pat_d;
            flag_q       <= flag_d;
            abort_q      <= abort_d;
            skip_q       <= skip_d;
            ones_q       <= ones_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            any_bits_q   <= any_bits_d;
            byte_cnt_q   <= byte_cnt_d;
            ovf_q        <= ovf_d;
            data_q       <= data_d;
            newbyte_q    <= newbyte_d;
            wrbuff_q     <= wrbuff_d;
            abort_sig_q  <= abort_sig_d;
            prev_frame_q <= prev_frame_d;
            eof_q        <= eof_d;
            fe_pend_q    <= fe_pend_d;
            fe_q         <= fe_d;
        end
    end

    assign Rx_Data        = data_q;
    assign Rx_NewByte     = newbyte_q;
    assign Rx_WrBuff      = wrbuff_q;
    assign Rx_FlagDetect  = flag_q;
    assign Rx_AbortDetect = abort_q;
    assign Rx_ValidFrame  = in_frame;
    assign Rx_EoF         = eof_q;
    assign Rx_AbortSignal = abort_sig_q;
    assign Rx_Overflow    = ovf_q;
    assign Rx_FrameError  = fe_q;

endmodule
